fwd_hazard_ctrl: RTL

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/mips_pkg.sv | 33 +++
 rtl/fwd_sel_unit.sv | 34 +++
 rtl/fwd_hazard_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline types for the forwarding/hazard controller: stage records,
// operand-mux select encodings and the record "hit" test.
package mips_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    // Operand mux select; 2'd3 is never produced.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_read;
    } stage_rec_t;

    localparam stage_rec_t EMPTY_REC = '0;

    // A record produces register r only when it is live, writes back, and r is not $0.
    function automatic logic rec_hits(input stage_rec_t rec, input logic [REG_W-1:0] r);
        return rec.valid && rec.reg_write && (rec.dest == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding select: newest producer (MEM) beats older one (WB),
// otherwise the register-file value is used.
module fwd_sel_unit
    import mips_pkg::*;
(
    input  logic             src_used,
    input  logic [REG_W-1:0] src_reg,
    input  stage_rec_t       mem_rec,
    input  stage_rec_t       wb_rec,
    output logic [1:0]       sel
);

    logic mem_hit;
    logic wb_hit;
    logic unused_rec_fields;

    assign mem_hit = src_used && rec_hits(mem_rec, src_reg);
    assign wb_hit  = src_used && rec_hits(wb_rec, src_reg);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    // Source-side fields of the older records play no part in forwarding.
    assign unused_rec_fields = ^{mem_rec.rs, mem_rec.rt, mem_rec.uses_rs, mem_rec.uses_rt,
                                 mem_rec.mem_read, wb_rec.rs, wb_rec.rt, wb_rec.uses_rs,
                                 wb_rec.uses_rt, wb_rec.mem_read};

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline: tracks EX/MEM/WB
// records, drives ALU operand selects, stalls one cycle on load-use, counts stalls.
module fwd_hazard_ctrl
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count
);

    stage_rec_t       id_rec;
    stage_rec_t       ex_q;
    stage_rec_t       mem_q;
    stage_rec_t       wb_q;
    logic             load_use;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        id_rec           = EMPTY_REC;
        id_rec.valid     = id_valid;
        id_rec.rs        = id_rs;
        id_rec.rt        = id_rt;
        id_rec.uses_rs   = id_uses_rs;
        id_rec.uses_rt   = id_uses_rt;
        id_rec.dest      = id_dest;
        id_rec.reg_write = id_reg_write;
        id_rec.mem_read  = id_mem_read;
    end

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    assign load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) &&
                      ((id_uses_rs && (ex_q.dest == id_rs)) ||
                       (id_uses_rt && (ex_q.dest == id_rt)));

    // A flush squashes the ID instruction, so its dependency no longer matters.
    assign stall = load_use && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= EMPTY_REC;
            mem_q       <= EMPTY_REC;
            wb_q        <= EMPTY_REC;
            stall_cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (stall || flush) ? EMPTY_REC : id_rec;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    fwd_sel_unit u_fwd_a (
        .src_used (ex_q.uses_rs),
        .src_reg  (ex_q.rs),
        .mem_rec  (mem_q),
        .wb_rec   (wb_q),
        .sel      (fwd_a_sel)
    );

    fwd_sel_unit u_fwd_b (
        .src_used (ex_q.uses_rt),
        .src_reg  (ex_q.rt),
        .mem_rec  (mem_q),
        .wb_rec   (wb_q),
        .sel      (fwd_b_sel)
    );

    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = !reset && (stall || flush);
    assign stall_count = stall_cnt_q;

endmodule
